// File: rtl/drac_pkg.sv
// Shared types and defaults for the drac DDR3 line-port arbiter, the controller and its adapters.
package drac_pkg;

  localparam int DRAC_AW = 29;
  localparam int DRAC_DW = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } drac_state_e;

  function automatic int drac_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/drac_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping N-1 -> 0.
module drac_rr_pick
  import drac_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = drac_clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [2*N-1:0] req2;
  logic [2*N-1:0] shifted;
  logic [N-1:0]   rot;
  logic [IW-1:0]  pos;
  logic [IW:0]    sum;

  always_comb begin
    req2    = {req_i, req_i};
    shifted = req2 >> ptr_i;
    rot     = shifted[N-1:0];
    pos     = '0;
    valid_o = 1'b0;
    // Descending scan so the lowest rotated position wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pos     = IW'(i);
        valid_o = 1'b1;
      end
    end
    sum = {1'b0, ptr_i} + {1'b0, pos};
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
    idx_o = sum[IW-1:0];
    gnt_o = '0;
    if (valid_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/drac_port_arbiter.sv
// Round-robin arbiter sharing drac_ddr3's single line port between NCH masters, one transaction in flight.
// Build option DRAC_ARB_CH0_PRIO_EN makes channel 0 strict-priority over a round-robin pool of 1..NCH-1.
module drac_port_arbiter
  import drac_pkg::*;
#(
  parameter int NCH = 4,
  parameter int AW  = DRAC_AW,
  parameter int DW  = DRAC_DW
) (
  input  logic                  ckdr,
  input  logic                  reset,
  input  logic [NCH-1:0]        c_rd,
  input  logic [NCH-1:0]        c_wr,
  input  logic [NCH*AW-1:0]     c_a,
  input  logic [NCH*DW-1:0]     c_wdat,
  input  logic [NCH*(DW/8)-1:0] c_msk,
  output logic [NCH-1:0]        c_ack,
  output logic [DW-1:0]         c_rdat,
  output logic                  srd,
  output logic                  swr,
  output logic [AW-1:0]         sa,
  output logic [DW-1:0]         swdat,
  output logic [DW/8-1:0]       smsk,
  input  logic [DW-1:0]         srdat,
  input  logic                  srdy
);

  localparam int MW = DW / 8;
  localparam int IW = drac_clog2(NCH);

  drac_state_e    state_q;
  logic           srd_q, swr_q, rd_dir_q;
  logic [AW-1:0]  sa_q;
  logic [DW-1:0]  swdat_q, rdat_q;
  logic [MW-1:0]  smsk_q;
  logic [NCH-1:0] ack_q, gnt_oh_q;
  logic [IW-1:0]  grant_q, rr_q, rr_d;
  logic [IW:0]    rr_inc;

  logic [NCH-1:0] req;
  logic [NCH-1:0] pick_gnt;
  logic [IW-1:0]  pick_idx;
  logic           pick_valid;

  logic [AW-1:0] a_arr    [NCH];
  logic [DW-1:0] wdat_arr [NCH];
  logic [MW-1:0] msk_arr  [NCH];

  assign req = c_rd | c_wr;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
    assign a_arr[gi]    = c_a[gi*AW +: AW];
    assign wdat_arr[gi] = c_wdat[gi*DW +: DW];
    assign msk_arr[gi]  = c_msk[gi*MW +: MW];
  end

`ifdef DRAC_ARB_CH0_PRIO_EN
  logic [NCH-1:0] pool_gnt;
  logic [IW-1:0]  pool_idx;
  logic           pool_valid;

  drac_rr_pick #(.N(NCH), .IW(IW)) u_pick (
    .req_i   ({req[NCH-1:1], 1'b0}),
    .ptr_i   (rr_q),
    .gnt_o   (pool_gnt),
    .idx_o   (pool_idx),
    .valid_o (pool_valid)
  );

  always_comb begin
    pick_gnt   = pool_gnt;
    pick_idx   = pool_idx;
    pick_valid = pool_valid;
    if (req[0]) begin
      pick_gnt   = NCH'(1);
      pick_idx   = '0;
      pick_valid = 1'b1;
    end
  end
`else
  drac_rr_pick #(.N(NCH), .IW(IW)) u_pick (
    .req_i   (req),
    .ptr_i   (rr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );
`endif

  always_comb begin
    rr_inc = {1'b0, grant_q} + (IW+1)'(1);
    if (rr_inc == (IW+1)'(NCH)) rr_inc = '0;
    rr_d = rr_inc[IW-1:0];
`ifdef DRAC_ARB_CH0_PRIO_EN
    // Channel 0 sits outside the rotation, so its grants leave the pool pointer alone.
    if (grant_q == '0) rr_d = rr_q;
`endif
  end

  always_ff @(posedge ckdr) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      srd_q    <= 1'b0;
      swr_q    <= 1'b0;
      rd_dir_q <= 1'b0;
      sa_q     <= '0;
      swdat_q  <= '0;
      smsk_q   <= '0;
      rdat_q   <= '0;
      ack_q    <= '0;
      gnt_oh_q <= '0;
      grant_q  <= '0;
      rr_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_q  <= pick_idx;
            gnt_oh_q <= pick_gnt;
            sa_q     <= a_arr[pick_idx];
            swdat_q  <= wdat_arr[pick_idx];
            smsk_q   <= msk_arr[pick_idx];
            rd_dir_q <= c_rd[pick_idx];
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // srdy only counts once the request is actually on the port.
          if (srd_q || swr_q) begin
            if (srdy) begin
              srd_q   <= 1'b0;
              swr_q   <= 1'b0;
              ack_q   <= gnt_oh_q;
              rr_q    <= rr_d;
              state_q <= ST_DONE;
              if (rd_dir_q) rdat_q <= srdat;
            end
          end else begin
            srd_q <= rd_dir_q;
            swr_q <= ~rd_dir_q;
          end
        end
        ST_DONE: begin
          ack_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign c_ack  = ack_q;
  assign c_rdat = rdat_q;
  assign srd    = srd_q;
  assign swr    = swr_q;
  assign sa     = sa_q;
  assign swdat  = swdat_q;
  assign smsk   = smsk_q;

endmodule

// File: tb/tb_drac_port_arbiter.sv
// Directed bench for drac_port_arbiter with a cycle-stepped drac_ddr3 responder.
module tb_drac_port_arbiter;

  localparam int NCH = 4;
  localparam int AW  = 29;
  localparam int DW  = 256;
  localparam int MW  = DW / 8;

  logic                  ckdr = 1'b0;
  logic                  reset = 1'b1;
  logic [NCH-1:0]        c_rd = '0;
  logic [NCH-1:0]        c_wr = '0;
  logic [NCH*AW-1:0]     c_a = '0;
  logic [NCH*DW-1:0]     c_wdat = '0;
  logic [NCH*MW-1:0]     c_msk = '0;
  logic [NCH-1:0]        c_ack;
  logic [DW-1:0]         c_rdat;
  logic                  srd, swr;
  logic [AW-1:0]         sa;
  logic [DW-1:0]         swdat;
  logic [MW-1:0]         smsk;
  logic [DW-1:0]         srdat = '0;
  logic                  srdy = 1'b0;

  int            n_checks = 0;
  int            n_fail = 0;
  int            cnt = 0;
  int            srdy_delay = 5;
  bit            stray_srdy = 1'b0;
  logic          last_rd = 1'b0;
  logic [DW-1:0] model_rdat = '0;

  drac_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
    .ckdr   (ckdr),
    .reset  (reset),
    .c_rd   (c_rd),
    .c_wr   (c_wr),
    .c_a    (c_a),
    .c_wdat (c_wdat),
    .c_msk  (c_msk),
    .c_ack  (c_ack),
    .c_rdat (c_rdat),
    .srd    (srd),
    .swr    (swr),
    .sa     (sa),
    .swdat  (swdat),
    .smsk   (smsk),
    .srdat  (srdat),
    .srdy   (srdy)
  );

  always #5 ckdr = ~ckdr;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock step; the DDR responder answers srdy_delay cycles after it sees srd/swr.
  task automatic tick();
    @(posedge ckdr);
    #1;
    if (reset) begin
      srdy = 1'b0;
      cnt  = 0;
    end else if (srdy) begin
      srdy = 1'b0;
    end else if (stray_srdy) begin
      srdy       = 1'b1;
      stray_srdy = 1'b0;
    end else if (srd || swr) begin
      cnt++;
      if (cnt >= srdy_delay) begin
        srdy  = 1'b1;
        srdat = model_rdat;
        cnt   = 0;
      end
    end else begin
      cnt = 0;
    end
    if (srd) last_rd = 1'b1;
    else if (swr) last_rd = 1'b0;
  endtask

  task automatic wait_ack(output logic [NCH-1:0] ack, output int cyc);
    ack = '0;
    cyc = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      cyc++;
      if (c_ack != '0) begin
        ack = c_ack;
        $display("txn ack=%b dir=%s sa=%0h rdat=%0h", c_ack, last_rd ? "rd" : "wr", sa, c_rdat[31:0]);
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL ack_timeout: got no c_ack expected a pulse within 60 cycles");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [DW-1:0] wdat_of(input int k);
    return {224'h0, 32'hC0DE_0000 + 32'(k)};
  endfunction

  function automatic logic [MW-1:0] msk_of(input int k);
    return 32'h1 << k;
  endfunction

  logic [NCH-1:0] ack;
  int             cyc;
  int             ch;
  logic [NCH-1:0] exp2 [5];
  int             ch2  [5];
  logic [NCH-1:0] exp5 [5];
  int             ch3  [4];
  logic           rd3  [4];

  initial begin
    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check_eq("rst_srd", DW'(srd), DW'(0));
    check_eq("rst_swr", DW'(swr), DW'(0));
    check_eq("rst_sa", DW'(sa), DW'(0));
    check_eq("rst_smsk", DW'(smsk), DW'(0));
    check_eq("rst_ack", DW'(c_ack), DW'(0));
    check_eq("rst_rdat", c_rdat, DW'(0));
    reset = 1'b0;
    tick();

    // 1: single ch2 read
    model_rdat = {32{8'hA5}};
    c_a[2*AW +: AW] = 29'h0000123;
    c_rd[2] = 1'b1;
    tick();
    check_eq("t1_srd_cyc1", DW'(srd), DW'(0));
    tick();
    check_eq("t1_srd_cyc2", DW'(srd), DW'(1));
    check_eq("t1_swr_cyc2", DW'(swr), DW'(0));
    check_eq("t1_sa", DW'(sa), DW'(29'h0000123));
    wait_ack(ack, cyc);
    c_rd[2] = 1'b0;
    check_eq("t1_ack", DW'(ack), DW'(4'b0100));
    check_eq("t1_ack_latency", DW'(cyc), DW'(5));
    check_eq("t1_rdat", c_rdat, {32{8'hA5}});
    check_eq("t1_srd_drop", DW'(srd), DW'(0));
    tick();
    check_eq("t1_ack_pulse", DW'(c_ack), DW'(0));

    // 6: masked write leaves c_rdat alone
    model_rdat = {32{8'h5A}};
    c_a[2*AW +: AW] = 29'h1ABCDE;
    c_wdat[2*DW +: DW] = wdat_of(9);
    c_msk[2*MW +: MW] = 32'hFFFF_FFF0;
    c_wr[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (swr) break;
    end
    check_eq("t6_swr", DW'(swr), DW'(1));
    check_eq("t6_srd", DW'(srd), DW'(0));
    check_eq("t6_smsk", DW'(smsk), DW'(32'hFFFF_FFF0));
    check_eq("t6_swdat", swdat, wdat_of(9));
    check_eq("t6_sa", DW'(sa), DW'(29'h1ABCDE));
    wait_ack(ack, cyc);
    c_wr[2] = 1'b0;
    check_eq("t6_ack", DW'(ack), DW'(4'b0100));
    check_eq("t6_rdat_kept", c_rdat, {32{8'hA5}});

    // 2: all four channels write, held
    do_reset();
    for (int k = 0; k < NCH; k++) begin
      c_wdat[k*DW +: DW] = wdat_of(k);
      c_msk[k*MW +: MW] = msk_of(k);
      c_a[k*AW +: AW] = 29'(k + 16);
    end
`ifdef DRAC_ARB_CH0_PRIO_EN
    exp2 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    ch2  = '{0, 0, 0, 0, 0};
`else
    exp2 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ch2  = '{0, 1, 2, 3, 0};
`endif
    c_wr = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ack(ack, cyc);
      if (i == 4) c_wr = '0;
      ch = ch2[i];
      check_eq("t2_order", DW'(ack), DW'(exp2[i]));
      check_eq("t2_swdat", swdat, wdat_of(ch));
      check_eq("t2_smsk", DW'(smsk), DW'(msk_of(ch)));
    end

    // 3: ch1 read+write, ch2 read, ch3 write
    do_reset();
    ch3 = '{1, 2, 3, 1};
    rd3 = '{1'b1, 1'b1, 1'b0, 1'b0};
    c_rd = 4'b0110;
    c_wr = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      wait_ack(ack, cyc);
      if (i == 0) c_rd[1] = 1'b0;
      if (i == 3) begin
        c_rd = '0;
        c_wr = '0;
      end
      check_eq("t3_order", DW'(ack), DW'(4'b0001 << ch3[i]));
      check_eq("t3_dir", DW'(last_rd), DW'(rd3[i]));
    end
    tick();

    // 4: reset in ISSUE with srdy pending
    srdy_delay = 1000;
    c_rd[3] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (srd) break;
    end
    check_eq("t4_srd_before", DW'(srd), DW'(1));
    reset = 1'b1;
    tick();
    check_eq("t4_srd_rst", DW'(srd), DW'(0));
    check_eq("t4_swr_rst", DW'(swr), DW'(0));
    check_eq("t4_ack_rst", DW'(c_ack), DW'(0));
    check_eq("t4_sa_rst", DW'(sa), DW'(0));
    c_rd = '0;
    reset = 1'b0;
    srdy_delay = 5;
    tick();
    stray_srdy = 1'b1;
    tick();
    tick();
    check_eq("t4_stray_ack", DW'(c_ack), DW'(0));
    tick();
    check_eq("t4_stray_ack2", DW'(c_ack), DW'(0));
    check_eq("t4_stray_srd", DW'(srd), DW'(0));
    c_wr = 4'b1001;
    wait_ack(ack, cyc);
    c_wr = '0;
    check_eq("t4_rr_reset", DW'(ack), DW'(4'b0001));
    tick();

    // 5: ch0 and ch3 always requesting, ch0 drops after four grants
    do_reset();
`ifdef DRAC_ARB_CH0_PRIO_EN
    exp5 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1000};
`else
    exp5 = '{4'b0001, 4'b1000, 4'b0001, 4'b1000, 4'b1000};
`endif
    c_wr = 4'b1001;
    for (int i = 0; i < 5; i++) begin
      wait_ack(ack, cyc);
      if (i == 3) c_wr[0] = 1'b0;
      if (i == 4) c_wr = '0;
      check_eq("t5_order", DW'(ack), DW'(exp5[i]));
    end
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
